// File: rtl/bus_shim_pkg.sv
// Shared types and constants for the MIPS bus stall shim: FSM states, stall
// modes, monitor error codes and the LFSR step function.
package bus_shim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STALL = 2'd1,
    ST_FWD   = 2'd2
  } state_e;

  localparam int MODE_FIXED  = 0;
  localparam int MODE_FIRST  = 1;
  localparam int MODE_RANDOM = 2;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_RW_BOTH = 2'b01;
  localparam logic [1:0] ERR_CHANGED = 2'b10;
  localparam logic [1:0] ERR_BE_ZERO = 2'b11;

  // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR map to state bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/bus_shim_lfsr.sv
// 16-bit Fibonacci LFSR that steps once per advance strobe; drives the
// pseudo-random stall length of the shim.
module bus_shim_lfsr
  import bus_shim_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_advance,
  output logic [15:0] o_state
);

  logic [15:0] r_state;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= SEED;
    end else if (i_advance) begin
      r_state <= lfsr_next(r_state);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/mips_bus_stall_shim.sv
// Avalon-style wait-state injector between the mips_cpu_bus master and a memory
// slave, with a master-side handshake monitor and saturating statistics.
module mips_bus_stall_shim
  import bus_shim_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter int          MODE      = 0,
  parameter int          RD_WAIT   = 1,
  parameter int          WR_WAIT   = 3,
  parameter int          MAX_WAIT  = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m_address,
  input  logic                m_read,
  input  logic                m_write,
  input  logic [DATA_W-1:0]   m_writedata,
  input  logic [DATA_W/8-1:0] m_byteenable,
  output logic                m_waitrequest,
  output logic [DATA_W-1:0]   m_readdata,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  output logic [15:0]         rd_count,
  output logic [15:0]         wr_count,
  output logic [31:0]         stall_count,
  output logic                proto_err,
  output logic [1:0]          err_code
);

  localparam int BE_W = DATA_W / 8;

  state_e            r_state;
  logic [15:0]       r_cnt;
  logic              r_op_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;
  logic              r_first_rd;
  logic              r_first_wr;
  logic [15:0]       r_rd_count;
  logic [15:0]       r_wr_count;
  logic [31:0]       r_stall_count;
  logic              r_proto_err;
  logic [1:0]        r_err_code;

  logic        w_accept;
  logic [15:0] w_lfsr;
  logic [15:0] w_n;
  logic        w_fwd_now;
  logic        w_done;
  logic        w_inject;
  logic        w_mismatch;
  logic        w_err_set;
  logic [1:0]  w_err_code;

  assign w_accept = (r_state == ST_IDLE) && (m_read ^ m_write);

  bus_shim_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk       (clk),
    .reset     (reset),
    .i_advance (w_accept),
    .o_state   (w_lfsr)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_n = '0;
    case (MODE)
      MODE_FIXED:  w_n = m_read ? 16'(RD_WAIT) : 16'(WR_WAIT);
      MODE_FIRST:  w_n = m_read ? (r_first_rd ? 16'(RD_WAIT) : 16'd0)
                                : (r_first_wr ? 16'(WR_WAIT) : 16'd0);
      MODE_RANDOM: w_n = 16'(32'(w_lfsr[7:0]) % 32'(MAX_WAIT + 1));
      default:     w_n = '0;
    endcase
  end

  // A zero-stall request is forwarded in its acceptance cycle, exactly as FWD would.
  assign w_fwd_now = w_accept && (w_n == 16'd0);
  assign w_done    = (w_fwd_now || (r_state == ST_FWD)) && !s_waitrequest;
  assign w_inject  = (w_accept && (w_n != 16'd0)) || (r_state == ST_STALL);

  always_comb begin
    m_waitrequest = w_inject;
    m_readdata    = '0;
    s_address     = '0;
    s_read        = 1'b0;
    s_write       = 1'b0;
    s_writedata   = '0;
    s_byteenable  = '0;
    if (r_state == ST_FWD) begin
      s_address     = r_addr;
      s_read        = !r_op_wr;
      s_write       = r_op_wr;
      s_writedata   = r_wdata;
      s_byteenable  = r_be;
      m_waitrequest = s_waitrequest;
      m_readdata    = s_readdata;
    end else if (w_fwd_now) begin
      s_address     = m_address;
      s_read        = m_read;
      s_write       = m_write;
      s_writedata   = m_writedata;
      s_byteenable  = m_byteenable;
      m_waitrequest = s_waitrequest;
      m_readdata    = s_readdata;
    end
  end

  // The master must hold its request unchanged until waitrequest drops.
  assign w_mismatch = (m_address != r_addr) || (m_byteenable != r_be) ||
                      (r_op_wr ? (!m_write || m_read || (m_writedata != r_wdata))
                               : (!m_read || m_write));

  always_comb begin
    w_err_set  = 1'b0;
    w_err_code = ERR_NONE;
    if (r_state == ST_IDLE) begin
      if (m_read && m_write) begin
        w_err_set  = 1'b1;
        w_err_code = ERR_RW_BOTH;
      end else if (m_write && (m_byteenable == '0)) begin
        w_err_set  = 1'b1;
        w_err_code = ERR_BE_ZERO;
      end
    end else if (w_mismatch) begin
      w_err_set  = 1'b1;
      w_err_code = ERR_CHANGED;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_op_wr       <= 1'b0;
      // NOTE: the request latch is reset too, so slave outputs never carry X.
      r_addr        <= '0;
      r_wdata       <= '0;
      r_be          <= '0;
      r_first_rd    <= 1'b1;
      r_first_wr    <= 1'b1;
      r_rd_count    <= '0;
      r_wr_count    <= '0;
      r_stall_count <= '0;
      r_proto_err   <= 1'b0;
      r_err_code    <= ERR_NONE;
    end else begin
      if (w_done && !r_op_wr && (r_state == ST_FWD || m_read) && r_rd_count != '1)
        r_rd_count <= r_rd_count + 16'd1;
      if (w_done && (r_state == ST_FWD ? r_op_wr : m_write) && r_wr_count != '1)
        r_wr_count <= r_wr_count + 16'd1;
      if (w_inject && r_stall_count != '1)
        r_stall_count <= r_stall_count + 32'd1;
      if (w_err_set && !r_proto_err) begin
        r_proto_err <= 1'b1;
        r_err_code  <= w_err_code;
      end

      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_op_wr <= m_write;
          r_addr  <= m_address;
          r_wdata <= m_writedata;
          r_be    <= m_byteenable;
          if (m_read) r_first_rd <= 1'b0;
          else        r_first_wr <= 1'b0;
          if (w_n == 16'd0) begin
            r_state <= s_waitrequest ? ST_FWD : ST_IDLE;
          end else begin
            r_cnt   <= w_n - 16'd1;
            r_state <= (w_n > 16'd1) ? ST_STALL : ST_FWD;
          end
        end
        ST_STALL: begin
          if (r_cnt == 16'd1) r_state <= ST_FWD;
          else                r_cnt   <= r_cnt - 16'd1;
        end
        ST_FWD: if (!s_waitrequest) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rd_count    = r_rd_count;
  assign wr_count    = r_wr_count;
  assign stall_count = r_stall_count;
  assign proto_err   = r_proto_err;
  assign err_code    = r_err_code;

endmodule
